// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Included by the byte packer and the loader FSM.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } boot_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CHK_W          = 8;

endpackage

// File: rtl/word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words and emits a
// one-cycle word_valid pulse the cycle after the last byte of each word.
module word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int SHR_W = 8 * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SHR_W-1:0] shift_q, shift_d;
  logic [31:0]      word_q, word_d;
  logic             word_valid_q, word_valid_d;

  assign last_byte  = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_valid = word_valid_q;
  assign word       = word_q;

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      // Newest byte enters at the top so the first byte ends up in [7:0].
      shift_d = {byte_data, shift_q[SHR_W-1:8]};
      if (last_byte) begin
        word_d       = {byte_data, shift_q};
        word_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: loads instruction memory from a byte stream, verifies an
// XOR checksum, and releases the core from reset only on a good load.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int            CNT_W     = HDR_BYTES * 8;
  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(2 ** ADDR_W);

  boot_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CHK_W-1:0]  checksum_q, checksum_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic [CNT_W-1:0]  hdr_count;
  logic              accept;
  logic              packer_clear;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word;

  assign rx_ready     = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign busy         = rx_ready;
  assign done         = (state_q == ST_RUN);
  assign error        = (state_q == ST_ERR);
  assign core_reset   = (state_q != ST_RUN);
  assign accept       = rx_valid && rx_ready;
  assign hdr_count    = {rx_data, count_q[7:0]};
  assign imem_we      = word_valid;
  assign imem_wdata   = word;
  assign imem_addr    = words_loaded_q[ADDR_W-1:0];
  assign words_loaded = words_loaded_q;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    checksum_d     = checksum_q;
    words_loaded_d = words_loaded_q;
    packer_clear   = 1'b0;
    if (word_valid) begin
      words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
    end
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d        = ST_HDR_LO;
          words_loaded_d = '0;
          checksum_d     = '0;
          packer_clear   = 1'b1;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          count_d = {count_q[CNT_W-1:8], rx_data};
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          count_d = hdr_count;
          if ((hdr_count == '0) || ({1'b0, hdr_count} > MAX_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          checksum_d = checksum_q ^ rx_data;
          // count_q holds the words still to be received.
          if (last_byte) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = ST_CHK;
            end
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          state_d = (rx_data == checksum_q) ? ST_RUN : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      checksum_q     <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      checksum_q     <= checksum_d;
      words_loaded_q <= words_loaded_d;
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot sequencer for the single-cycle RISC-V core with memories. It holds the core in reset while it loads instruction memory from an 8-bit byte stream (valid/ready) and checks the load with an XOR checksum. On a good load it releases the core. On a bad load it keeps the core in reset and flags an error. It sits between the host byte source and the instruction-memory write port, and drives the core's reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
HDR_BYTES, 2, header length in bytes: 16-bit little-endian word count. Fixed constant, not overridable.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  one-cycle pulse; begins (or restarts) a load
rx_data  in  8  stream byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts byte; transfer when rx_valid & rx_ready at posedge
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_W  word address of write
imem_wdata  out  32  word to write
core_reset  out  1  reset to core; 1 = core held
busy  out  1  load in progress (HDR_LO..CHK)
done  out  1  load completed, core running
error  out  1  load failed
words_loaded  out  ADDR_W+1  words written in current load

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE, core_reset=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, byte counter=0, checksum=0.
- States: IDLE, HDR_LO, HDR_HI, DATA, CHK, RUN, ERR. All outputs are registered or decoded from the state register only.
- rx_ready=1 only in HDR_LO, HDR_HI, DATA and CHK. busy=1 in the same states.
- IDLE: start -> HDR_LO. Clear words_loaded, checksum and byte counter.
- HDR_LO: on accept, count[7:0]=rx_data -> HDR_HI.
- HDR_HI: on accept, count[15:8]=rx_data.
  - count==0 or count>2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA: each accepted byte XORs into checksum. Bytes pack little-endian: the first byte goes to [7:0].
  - On the 4th byte of a word, the next cycle has imem_we=1 for exactly one cycle, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=packed word.
  - words_loaded increments in that same cycle.
  - Write latency is 1 cycle after the 4th byte is accepted. rx_ready stays high; a new byte may be accepted during the write cycle.
  - After the 4th byte of word count-1 is accepted -> CHK. The last write happens in the first CHK cycle.
- CHK: on accept, compare rx_data with checksum (payload bytes only; header excluded).
  - Equal -> RUN.
  - Unequal -> ERR.
- RUN: core_reset=0 and done=1, starting the cycle after the checksum byte is accepted. start -> core_reset=1 in the next cycle and go to HDR_LO (reload).
- ERR: error=1, core_reset=1. start -> HDR_LO (retry) and clear error.
- start in HDR_LO..CHK is ignored (no restart mid-load).
- rx_valid low stalls any state with no side effects; there is no timeout.
- Bytes offered while rx_ready=0 are not consumed.
- reset mid-load: the block returns to IDLE next cycle and core_reset stays 1. Partially written imem contents are left as-is.
- count==2**ADDR_W: the final write is at address 2**ADDR_W-1 and words_loaded reaches 2**ADDR_W. There is no wrap.

Decomposition:
- Package boot_pkg holds:
  - state enum boot_state_t;
  - HDR_BYTES=2;
  - BYTES_PER_WORD=4;
  - checksum width (8).
- One sub-module, word_packer: takes byte plus valid, keeps a 2-bit byte counter and 32-bit shift register, and outputs word_valid and word. Its counter is cleared by the FSM on start.

Test Plan:
- Good load: start, then bytes 02 00 | 13 05 10 00 | 93 05 20 00 | B0.
  - Expect imem_we pulses at addr 0 with 0x00100513 and addr 1 with 0x00200593.
  - Then done=1, core_reset=0 and words_loaded=2, one cycle after B0.
- Bad checksum: same stream ending in B1 -> error=1, core_reset stays 1, done=0. Then start plus the good stream -> done=1.
- Header bounds:
  - count 00 00 -> ERR after the 2nd header byte, with no imem_we.
  - count 0x0101 with ADDR_W=8 -> ERR.
  - count 0x0100 -> 256 writes, last at addr 0xFF.
- Backpressure: rx_valid toggled 1-0-1 randomly across the good load gives identical writes. Random start pulses mid-load are ignored.
- Reset mid-DATA: assert reset after 5 payload bytes -> next cycle IDLE, rx_ready=0, core_reset=1, words_loaded=0.
- Reload from RUN: start while running -> core_reset=1 next cycle. Loading a new 1-word image 01 00 | 6F 00 00 00 | 6F -> done=1, with the write at addr 0 = 0x0000006F.
